// File: rtl/pipeline_scoreboard_pkg.sv
// Shared RV32I pipeline types: scoreboard entry layout, forwarding and latency constants.
package rv32i_types;

   localparam int unsigned RV_REG_AW = 5;
   localparam int unsigned SB_LAT_W  = 2;

   // Entry layout for the default four-stage scoreboard configuration.
   typedef struct packed {
      logic                 valid;
      logic                 wen;
      logic [RV_REG_AW-1:0] rd;
      logic [SB_LAT_W-1:0]  lat;
   } sb_entry_t;

   localparam int unsigned FWD_REGFILE = 0;
   localparam int unsigned LAT_ALU     = 0;
   localparam int unsigned LAT_LOAD    = 1;

   // A writer's result can be forwarded once it has reached its latency stage.
   function automatic logic sb_ready(input int unsigned stage, input int unsigned lat);
      return stage >= lat;
   endfunction

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// Issue-side bundle between the ID stage and the scoreboard.
interface pipeline_scoreboard_if #(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned REG_AW     = 5
);
   localparam int unsigned LAT_W = $clog2(NUM_STAGES);
   localparam int unsigned SEL_W = $clog2(NUM_STAGES + 1);

   logic                              advance;
   logic                              issue_valid;
   logic                              issue_wen;
   logic [REG_AW-1:0]                 issue_rd;
   logic [LAT_W-1:0]                  issue_lat;
   logic [NUM_SRC-1:0][REG_AW-1:0]    src_addr;
   logic [NUM_STAGES:0]               flush_mask;
   logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel;
   logic                              stall;
   logic [31:0]                       stall_count;

   modport master (
      output advance, issue_valid, issue_wen, issue_rd, issue_lat, src_addr, flush_mask,
      input  fwd_sel, stall, stall_count
   );

   modport slave (
      input  advance, issue_valid, issue_wen, issue_rd, issue_lat, src_addr, flush_mask,
      output fwd_sel, stall, stall_count
   );

endinterface

// File: rtl/pipeline_scoreboard_sb_src_lookup.sv
// Per-source lookup: youngest matching writer decides between forward and block.
module sb_src_lookup
   import rv32i_types::*;
#(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned LAT_W      = $clog2(NUM_STAGES),
   parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic [NUM_STAGES-1:0]             ent_valid,
   input  logic [NUM_STAGES-1:0]             ent_wen,
   input  logic [NUM_STAGES-1:0][REG_AW-1:0] ent_rd,
   input  logic [NUM_STAGES-1:0][LAT_W-1:0]  ent_lat,
   input  logic [REG_AW-1:0]                 src_addr,
   output logic [SEL_W-1:0]                  fwd_sel,
   output logic                              blocked
);

   logic hit;

   always_comb begin
      fwd_sel = SEL_W'(FWD_REGFILE);
      blocked = 1'b0;
      hit     = 1'b0;
      // Ascending scan with a hit latch: the first match is the youngest writer,
      // and an unready youngest writer must block rather than expose an older value.
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
         if (!hit && ent_valid[k] && ent_wen[k] &&
             (ent_rd[k] == src_addr) && (src_addr != '0)) begin
            hit = 1'b1;
            if (sb_ready(k, 32'(ent_lat[k])))
               fwd_sel = SEL_W'(k + 1);
            else
               blocked = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Hazard scoreboard: tracks in-flight writers per stage, drives forwarding selects and issue stall.
module pipeline_scoreboard
   import rv32i_types::*;
#(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned LAT_W      = $clog2(NUM_STAGES),
   parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input logic                clk,
   input logic                rst,
   pipeline_scoreboard_if.slave sb
);

   logic [NUM_STAGES-1:0]             ent_valid;
   logic [NUM_STAGES-1:0]             ent_wen;
   logic [NUM_STAGES-1:0][REG_AW-1:0] ent_rd;
   logic [NUM_STAGES-1:0][LAT_W-1:0]  ent_lat;

   logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel;
   logic [NUM_SRC-1:0]                blocked;
   logic                              stall;
   logic                              issue_take;
   logic [31:0]                       stall_cnt_q;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lookup
      sb_src_lookup #(
         .NUM_STAGES (NUM_STAGES),
         .REG_AW     (REG_AW),
         .LAT_W      (LAT_W),
         .SEL_W      (SEL_W)
      ) u_lookup (
         .ent_valid (ent_valid),
         .ent_wen   (ent_wen),
         .ent_rd    (ent_rd),
         .ent_lat   (ent_lat),
         .src_addr  (sb.src_addr[gi]),
         .fwd_sel   (fwd_sel[gi]),
         .blocked   (blocked[gi])
      );
   end

   always_comb begin
      stall      = sb.issue_valid && !sb.flush_mask[0] && (|blocked);
      issue_take = sb.issue_valid && !stall && !sb.flush_mask[0];
   end

   // Flush of stage k is folded into the shift into stage k+1, so a flushed
   // entry simply never lands downstream; the retiring stage needs no flush term.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid   <= '0;
         stall_cnt_q <= '0;
      end else if (sb.advance) begin
         for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            ent_valid[k] <= ent_valid[k-1] && !sb.flush_mask[k];
            ent_wen[k]   <= ent_wen[k-1];
            ent_rd[k]    <= ent_rd[k-1];
            ent_lat[k]   <= ent_lat[k-1];
         end
         ent_valid[0] <= issue_take;
         ent_wen[0]   <= sb.issue_wen && (sb.issue_rd != '0);
         ent_rd[0]    <= sb.issue_rd;
         ent_lat[0]   <= sb.issue_lat;
         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign sb.fwd_sel     = fwd_sel;
   assign sb.stall       = stall;
   assign sb.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: hazards, forwarding, flush, freeze and reset.
module tb_pipeline_scoreboard;

   logic clk;
   logic rst;
   int unsigned n_checks;
   int unsigned n_errors;

   pipeline_scoreboard_if #(.NUM_STAGES(4), .NUM_SRC(2), .REG_AW(5)) sb_bus ();

   pipeline_scoreboard #(.NUM_STAGES(4), .NUM_SRC(2), .REG_AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      sb_bus.advance     = 1'b1;
      sb_bus.issue_valid = 1'b0;
      sb_bus.issue_wen   = 1'b0;
      sb_bus.issue_rd    = '0;
      sb_bus.issue_lat   = '0;
      sb_bus.src_addr[0] = '0;
      sb_bus.src_addr[1] = '0;
      sb_bus.flush_mask  = '0;
   endtask

   task automatic issue(input logic wen, input logic [4:0] rd, input logic [1:0] lat,
                        input logic [4:0] s0, input logic [4:0] s1);
      sb_bus.issue_valid = 1'b1;
      sb_bus.issue_wen   = wen;
      sb_bus.issue_rd    = rd;
      sb_bus.issue_lat   = lat;
      sb_bus.src_addr[0] = s0;
      sb_bus.src_addr[1] = s1;
      #1;
   endtask

   task automatic drain();
      set_idle();
      for (int i = 0; i < 5; i++) tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      set_idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check_eq("reset_stall", 32'(sb_bus.stall), 0);
      check_eq("reset_fwd0", 32'(sb_bus.fwd_sel[0]), 0);
      check_eq("reset_fwd1", 32'(sb_bus.fwd_sel[1]), 0);
      check_eq("reset_count", sb_bus.stall_count, 0);

      // ALU producer then back-to-back consumers
      issue(1'b1, 5'd1, 2'd0, 5'd0, 5'd0);
      check_eq("alu_issue_stall", 32'(sb_bus.stall), 0);
      tick();
      issue(1'b1, 5'd2, 2'd0, 5'd1, 5'd0);
      check_eq("alu_fwd_s0", 32'(sb_bus.fwd_sel[0]), 1);
      check_eq("alu_nostall", 32'(sb_bus.stall), 0);
      tick();
      issue(1'b0, 5'd0, 2'd0, 5'd1, 5'd0);
      check_eq("alu_fwd_s1", 32'(sb_bus.fwd_sel[0]), 2);
      tick();
      drain();

      // load-use on src1
      issue(1'b1, 5'd5, 2'd1, 5'd0, 5'd0);
      tick();
      issue(1'b1, 5'd6, 2'd0, 5'd0, 5'd5);
      check_eq("lu_stall", 32'(sb_bus.stall), 1);
      check_eq("lu_fwd_blocked", 32'(sb_bus.fwd_sel[1]), 0);
      tick();
      check_eq("lu_stall_clear", 32'(sb_bus.stall), 0);
      check_eq("lu_fwd", 32'(sb_bus.fwd_sel[1]), 2);
      check_eq("lu_count", sb_bus.stall_count, 1);
      tick();
      drain();

      // youngest unready writer shadows an older ready one
      issue(1'b1, 5'd3, 2'd0, 5'd0, 5'd0);
      tick();
      issue(1'b0, 5'd0, 2'd0, 5'd0, 5'd0);
      tick();
      issue(1'b1, 5'd3, 2'd1, 5'd0, 5'd0);
      check_eq("shadow_prod_nostall", 32'(sb_bus.stall), 0);
      tick();
      issue(1'b0, 5'd0, 2'd0, 5'd3, 5'd0);
      check_eq("shadow_stall", 32'(sb_bus.stall), 1);
      check_eq("shadow_fwd_blocked", 32'(sb_bus.fwd_sel[0]), 0);
      tick();
      check_eq("shadow_fwd", 32'(sb_bus.fwd_sel[0]), 2);
      check_eq("shadow_stall_clear", 32'(sb_bus.stall), 0);
      check_eq("shadow_count", sb_bus.stall_count, 2);
      tick();
      drain();

      // x0 never matches, even with a slow writer of rd=0
      issue(1'b1, 5'd0, 2'd1, 5'd0, 5'd0);
      tick();
      issue(1'b0, 5'd0, 2'd0, 5'd0, 5'd0);
      check_eq("x0_fwd0", 32'(sb_bus.fwd_sel[0]), 0);
      check_eq("x0_fwd1", 32'(sb_bus.fwd_sel[1]), 0);
      check_eq("x0_stall", 32'(sb_bus.stall), 0);
      tick();
      drain();

      // load-use with the pipeline frozen for three cycles
      issue(1'b1, 5'd7, 2'd1, 5'd0, 5'd0);
      tick();
      sb_bus.advance = 1'b0;
      issue(1'b0, 5'd0, 2'd0, 5'd7, 5'd0);
      for (int i = 0; i < 3; i++) begin
         check_eq("freeze_stall", 32'(sb_bus.stall), 1);
         check_eq("freeze_fwd", 32'(sb_bus.fwd_sel[0]), 0);
         check_eq("freeze_count", sb_bus.stall_count, 2);
         tick();
      end
      sb_bus.advance = 1'b1;
      #1;
      check_eq("thaw_stall", 32'(sb_bus.stall), 1);
      tick();
      check_eq("thaw_fwd", 32'(sb_bus.fwd_sel[0]), 2);
      check_eq("thaw_stall_clear", 32'(sb_bus.stall), 0);
      check_eq("thaw_count", sb_bus.stall_count, 3);
      tick();
      drain();

      // flush of issue and stage 0
      issue(1'b1, 5'd9, 2'd1, 5'd0, 5'd0);
      tick();
      sb_bus.flush_mask = 5'b00011;
      issue(1'b1, 5'd10, 2'd0, 5'd9, 5'd0);
      check_eq("flush_issue_stall", 32'(sb_bus.stall), 0);
      check_eq("flush_issue_fwd", 32'(sb_bus.fwd_sel[0]), 0);
      tick();
      sb_bus.flush_mask = '0;
      issue(1'b0, 5'd0, 2'd0, 5'd9, 5'd10);
      check_eq("flushed_fwd0", 32'(sb_bus.fwd_sel[0]), 0);
      check_eq("flushed_fwd1", 32'(sb_bus.fwd_sel[1]), 0);
      check_eq("flushed_stall", 32'(sb_bus.stall), 0);
      tick();
      drain();

      // flush of stage 0 alone does not change this cycle's lookup
      issue(1'b1, 5'd11, 2'd1, 5'd0, 5'd0);
      tick();
      sb_bus.flush_mask = 5'b00010;
      issue(1'b0, 5'd0, 2'd0, 5'd11, 5'd0);
      check_eq("flush_pre_stall", 32'(sb_bus.stall), 1);
      tick();
      sb_bus.flush_mask = '0;
      #1;
      check_eq("flush_post_stall", 32'(sb_bus.stall), 0);
      check_eq("flush_post_fwd", 32'(sb_bus.fwd_sel[0]), 0);
      check_eq("flush_count", sb_bus.stall_count, 4);
      tick();
      drain();

      // writer in WB still forwardable, gone after retiring
      issue(1'b1, 5'd13, 2'd0, 5'd0, 5'd0);
      tick();
      set_idle();
      for (int i = 0; i < 3; i++) tick();
      issue(1'b0, 5'd0, 2'd0, 5'd0, 5'd13);
      check_eq("wb_fwd", 32'(sb_bus.fwd_sel[1]), 4);
      tick();
      check_eq("retired_fwd", 32'(sb_bus.fwd_sel[1]), 0);
      drain();

      // reset in the middle of a stall
      issue(1'b1, 5'd12, 2'd1, 5'd0, 5'd0);
      tick();
      issue(1'b0, 5'd0, 2'd0, 5'd12, 5'd0);
      check_eq("rst_pre_stall", 32'(sb_bus.stall), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_eq("rst_stall", 32'(sb_bus.stall), 0);
      check_eq("rst_fwd", 32'(sb_bus.fwd_sel[0]), 0);
      check_eq("rst_count", sb_bus.stall_count, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_scoreboard.md
# pipeline_scoreboard

Parametrised hazard-detection and forwarding-control block for the next-generation RV32I pipeline. It replaces the fixed two-stage hdu/fwu pair with a scoreboard that tracks every in-flight register writer across a configurable number of post-issue stages. Each writer carries its own result latency, so loads, multi-cycle ALU ops and plain ALU ops are handled uniformly. It sits at the ID/EX boundary, consumes the issuing instruction's rd and source registers, and produces per-source forwarding selects, an issue stall, and a stall-cycle counter.

## Interface
- NUM_STAGES, 4: tracked stages after issue; stage 0 = EX, stage NUM_STAGES-1 = WB.
- NUM_SRC, 2: number of source-register lookups per issue.
- REG_AW, 5: register address width.
- LAT_W, $clog2(NUM_STAGES): width of a latency tag.
- SEL_W, $clog2(NUM_STAGES+1): width of a forwarding select.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- advance  in  1  pipeline moves this cycle (equivalent of dmem_resp && imem_resp).
- issue_valid  in  1  instruction in ID wants to enter stage 0.
- issue_wen  in  1  issuing instruction writes rd.
- issue_rd  in  REG_AW  destination register.
- issue_lat  in  LAT_W  first stage index at which the result is forwardable (0 = ALU, 1 = load).
- src_addr  in  NUM_SRC x REG_AW  source registers of the issuing instruction.
- flush_mask  in  NUM_STAGES+1  bit 0 kills the issuing instruction; bit k+1 kills the entry in stage k.
- fwd_sel  out  NUM_SRC x SEL_W  0 = regfile value; k+1 = forward from stage k.
- stall  out  1  hold ID and IF, and insert a bubble into stage 0.
- stall_count  out  32  saturating count of cycles with stall && advance.

## Operation
- State is one entry per stage: valid, wen, rd, lat.
- Entry in stage k is ready iff k >= lat.
- Lookup, per source s, combinational:
  - Candidates are valid entries with wen = 1, rd == src_addr[s], and rd != 0.
  - The youngest candidate (lowest k) wins.
  - If the winner is ready, fwd_sel[s] = k+1. Otherwise fwd_sel[s] = 0 and the source is blocked.
  - If there is no candidate, or src_addr[s] == 0, fwd_sel[s] = 0.
- stall = issue_valid && ~flush_mask[0] && (any source blocked).
- Update, applied only when advance = 1:
  - Entries in stages flagged by flush_mask[k+1] are invalidated first.
  - All entries then shift from stage k to stage k+1.
  - The stage NUM_STAGES-1 entry retires.
  - Stage 0 loads the issuing instruction iff issue_valid && ~stall && ~flush_mask[0]. Otherwise stage 0 loads a bubble (valid = 0).
- When advance = 0, all entries hold, including flush_mask effects. Flush takes effect only on an advancing cycle, matching the load gating of the pipeline registers.
- issue_wen with issue_rd = 0 is stored as wen = 0.
- stall_count increments when stall && advance, and saturates at 0xFFFFFFFF.

## Timing
- Reset (rst high at a clk edge): every entry valid = 0 and stall_count = 0. From the next cycle stall = 0 and all fwd_sel = 0. Reset overrides advance and flush.
- Outputs are combinational from registered state and the current inputs. There is no registered output except stall_count.
- Issue-to-visibility latency is 1 cycle: an instruction issued at edge t is in stage 0 and matchable after t.
- Load-use case, with lat = 1:
  - The consumer stalls exactly 1 advancing cycle.
  - It then forwards from stage 1 (fwd_sel = 2).
- With lat = L, a back-to-back dependent stalls L advancing cycles.
- The stall persists across non-advancing cycles without counting them.
- If the same rd is in stages 0 and 2, stage 0 wins even if it is not ready, and the consumer stalls. It must never take the stale stage 2 value.
- A flush of stage k in the same cycle as a consumer lookup does not affect that cycle's fwd_sel or stall; the lookup uses pre-update state.
- A retiring WB writer (stage NUM_STAGES-1) is still forwardable in its last cycle. The regfile is write-before-read on the following cycle.

## Structure
- The shared package rv32i_types gains sb_entry_t (valid, wen, rd, lat) and the constants FWD_REGFILE = 0 and LAT_ALU = 0, LAT_LOAD = 1.
- Sub-module sb_src_lookup: one instance per source. It takes the entry vector and a source address, and returns fwd_sel and blocked via a priority encoder from the youngest entry. The top level holds the entry shift register, the stall OR, and stall_count.

## Test plan
- Reset, then add x1 (lat 0) followed immediately by a consumer reading x1 in src0 -> no stall, fwd_sel[0] = 1. On the next issue of a reader of x1, fwd_sel[0] = 2.
- lw x5 (lat 1), then add reading x5 in src1 -> stall = 1 for 1 advancing cycle, stall_count = 1, then fwd_sel[1] = 2.
- Writers of x3 in stages 0 (lat 1) and 2, consumer reads x3 -> stall = 1, fwd_sel = 0. Next cycle fwd_sel = 2.
- Consumer reads x0 while a writer with rd = 0 is in flight -> fwd_sel = 0, stall = 0.
- Load-use stall with advance held low for 3 cycles -> stall stays 1, stall_count unchanged, entries frozen.
- flush_mask = 0b00011 during issue with a pending lat-1 stage-0 writer -> the stage 0 entry and the issue are dropped. A later reader of that rd gets fwd_sel = 0 and no stall. Asserting rst mid-stall clears stall next cycle.
